// File: rtl/apb_reg_bridge.sv
// rtl/apb_reg_bridge.sv - APB slave front end for the general-purpose register bank
//
// Purpose: decodes one APB transfer at a time, latches address/write data for
// the bank, issues a one-cycle read or write strobe, inserts the wait states
// the bank needs and returns read data or an out-of-range error response.
//
// Ports:
//   SYS_CLK    in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   PSEL       in   slave select
//   PENABLE    in   access phase indicator
//   PWRITE     in   1 = write, 0 = read
//   PADDR      in   register address
//   PWDATA     in   write data
//   PRDATA     out  read data, non-zero only on the completing cycle of a good read
//   PREADY     out  transfer complete
//   PSLVERR    out  error response, qualified by PREADY
//   read_flag  out  one-cycle read strobe to the bank
//   write_flag out  one-cycle write strobe to the bank
//   amba_addr  out  latched transfer address
//   data_in    out  latched write data
//   reg_rdata  in   bank read data (OR of all registers' data_out)

module apb_reg_bridge #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REGS   = 16
) (
  input  logic                  SYS_CLK,
  input  logic                  rst,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [DATA_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  output logic                  read_flag,
  output logic                  write_flag,
  output logic [DATA_WIDTH-1:0] amba_addr,
  output logic [DATA_WIDTH-1:0] data_in,
  input  logic [DATA_WIDTH-1:0] reg_rdata
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WRITE = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_RWAIT = 3'd3;
  localparam logic [2:0] S_ERR   = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  // One extra bit so NUM_REGS = 2^DATA_WIDTH is representable and never
  // matched by any address.
  localparam logic [DATA_WIDTH:0] LP_NUM_REGS = NUM_REGS[DATA_WIDTH:0];

  logic [2:0]            r_state;
  logic [2:0]            w_state_nxt;
  logic                  r_dir;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;

  logic w_setup;
  logic w_addr_bad;
  logic w_done;

  assign w_setup    = PSEL & ~PENABLE;
  assign w_addr_bad = ({1'b0, PADDR} >= LP_NUM_REGS);
  assign w_done     = (r_state == S_DONE);

  always_comb begin
    w_state_nxt = S_IDLE;
    case (r_state)
      S_IDLE: begin
        if (w_setup) begin
          if (w_addr_bad)  w_state_nxt = S_ERR;
          else if (PWRITE) w_state_nxt = S_WRITE;
          else             w_state_nxt = S_READ;
        end
      end
      // Dropping PSEL anywhere in the transfer abandons it without a response.
      S_WRITE: w_state_nxt = PSEL ? S_DONE  : S_IDLE;
      S_READ:  w_state_nxt = PSEL ? S_RWAIT : S_IDLE;
      S_RWAIT: w_state_nxt = PSEL ? S_DONE  : S_IDLE;
      S_ERR:   w_state_nxt = PSEL ? S_DONE  : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge SYS_CLK or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_dir   <= 1'b0;
      r_err   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && w_setup) begin
        r_addr  <= PADDR;
        r_wdata <= PWDATA;
        r_dir   <= PWRITE;
        r_err   <= w_addr_bad;
      end else if (w_state_nxt == S_IDLE) begin
        r_err   <= 1'b0;
      end
      // The bank registered its data_out at the end of READ, so it is
      // stable throughout RWAIT.
      if (r_state == S_RWAIT) begin
        r_rdata <= reg_rdata;
      end
    end
  end

  assign PREADY     = w_done;
  assign PSLVERR    = w_done & r_err;
  assign PRDATA     = (w_done & ~r_dir & ~r_err) ? r_rdata : '0;
  assign read_flag  = (r_state == S_READ);
  assign write_flag = (r_state == S_WRITE);
  assign amba_addr  = r_addr;
  assign data_in    = r_wdata;

endmodule

// File: tb/tb_apb_reg_bridge.sv
// tb/tb_apb_reg_bridge.sv - self-checking bench for apb_reg_bridge
module tb_apb_reg_bridge;

  logic       SYS_CLK = 1'b0;
  logic       rst;
  logic       PSEL, PENABLE, PWRITE;
  logic [7:0] PADDR, PWDATA, PRDATA, amba_addr, data_in, reg_rdata;
  logic       PREADY, PSLVERR, read_flag, write_flag;

  always #5 SYS_CLK = ~SYS_CLK;

  apb_reg_bridge #(.DATA_WIDTH(8), .NUM_REGS(16)) dut (
    .SYS_CLK(SYS_CLK), .rst(rst), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .read_flag(read_flag),
    .write_flag(write_flag), .amba_addr(amba_addr), .data_in(data_in),
    .reg_rdata(reg_rdata)
  );

  // Register bank stand-in: data_out registered on read_flag, zero otherwise.
  logic [7:0] bank_mem [16];
  logic [7:0] bank_dout;
  logic       bank_clr;
  always @(posedge SYS_CLK) begin
    if (bank_clr) begin
      for (int i = 0; i < 16; i++) bank_mem[i] <= 8'h00;
      bank_dout <= 8'h00;
    end else begin
      if (write_flag) bank_mem[amba_addr[3:0]] <= data_in;
      bank_dout <= read_flag ? bank_mem[amba_addr[3:0]] : 8'h00;
    end
  end
  assign reg_rdata = bank_dout;

  // Reference model: register contents as the bus should see them.
  logic [7:0] model_mem [16];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_cycle(input string tag, input bit rdy, input bit err,
                           input logic [7:0] rd, input bit rf, input bit wf);
    chk({tag, " PREADY"}, PREADY, rdy);
    chk({tag, " PSLVERR"}, PSLVERR, err);
    chk({tag, " PRDATA"}, PRDATA, rd);
    chk({tag, " read_flag"}, read_flag, rf);
    chk({tag, " write_flag"}, write_flag, wf);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge SYS_CLK); #1;
      PSEL = 1'b0; PENABLE = 1'b0;
      @(negedge SYS_CLK);
      chk_cycle("idle", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    end
  endtask

  // One APB transfer. drop_at = cycle (2..lat-1) in which PSEL is removed, 0 = none.
  task automatic xfer(input bit wr, input logic [7:0] a, input logic [7:0] d,
                      input bit e_err, input int e_lat, input logic [7:0] e_rd,
                      input int drop_at);
    bit good;
    good = !e_err;
    @(posedge SYS_CLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = d;
    @(negedge SYS_CLK);
    chk_cycle("T1", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int t = 2; t <= e_lat; t++) begin
      @(posedge SYS_CLK); #1;
      PENABLE = 1'b1;
      if (t == drop_at) begin PSEL = 1'b0; PENABLE = 1'b0; end
      PADDR  = 8'($urandom);
      PWDATA = 8'($urandom);
      @(negedge SYS_CLK);
      chk_cycle($sformatf("T%0d", t), t == e_lat, (t == e_lat) && e_err,
                (t == e_lat && !wr && good) ? e_rd : 8'h00,
                t == 2 && !wr && good, t == 2 && wr && good);
      chk("amba_addr", amba_addr, a);
      chk("data_in", data_in, d);
      if (t == drop_at) break;
    end
    if (wr && good) model_mem[a[3:0]] = d;
    if (drop_at != 0) idle(1);
  endtask

  typedef struct {
    bit         wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    bit         exp_err;
    int         exp_lat;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t vecs [10];

  initial begin
    vecs[0] = '{1'b1, 8'h03, 8'hA5, 1'b0, 3, 8'h00};
    vecs[1] = '{1'b0, 8'h03, 8'h5A, 1'b0, 4, 8'hA5};
    vecs[2] = '{1'b1, 8'h14, 8'h66, 1'b1, 3, 8'h00};
    vecs[3] = '{1'b0, 8'h03, 8'h00, 1'b0, 4, 8'hA5};
    vecs[4] = '{1'b1, 8'h00, 8'h3C, 1'b0, 3, 8'h00};
    vecs[5] = '{1'b0, 8'h00, 8'h12, 1'b0, 4, 8'h3C};
    vecs[6] = '{1'b1, 8'h0F, 8'hFF, 1'b0, 3, 8'h00};
    vecs[7] = '{1'b0, 8'h0F, 8'h00, 1'b0, 4, 8'hFF};
    vecs[8] = '{1'b0, 8'h10, 8'h00, 1'b1, 3, 8'h00};
    vecs[9] = '{1'b0, 8'hFF, 8'h00, 1'b1, 3, 8'h00};

    for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;
    rst = 1'b1; bank_clr = 1'b1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 8'h00; PWDATA = 8'h00;
    repeat (2) @(posedge SYS_CLK);
    @(negedge SYS_CLK);
    chk_cycle("reset", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("reset amba_addr", amba_addr, 8'h00);
    chk("reset data_in", data_in, 8'h00);
    rst = 1'b0; bank_clr = 1'b0;
    idle(1);

    // Back-to-back table: each T1 is the IDLE cycle after the previous DONE.
    for (int i = 0; i < 10; i++)
      xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_err,
           vecs[i].exp_lat, vecs[i].exp_rd, 0);
    idle(1);

    // Reset asserted during RWAIT of a read of reg 3.
    @(posedge SYS_CLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 8'h03; PWDATA = 8'h11;
    @(negedge SYS_CLK);
    chk_cycle("rst T1", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    @(posedge SYS_CLK); #1;
    PENABLE = 1'b1;
    @(negedge SYS_CLK);
    chk_cycle("rst T2", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    @(posedge SYS_CLK); #1;
    chk("rwait amba_addr", amba_addr, 8'h03);
    #2 rst = 1'b1;
    #1;
    chk_cycle("async rst", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("async rst amba_addr", amba_addr, 8'h00);
    chk("async rst data_in", data_in, 8'h00);
    @(posedge SYS_CLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    @(negedge SYS_CLK);
    chk_cycle("rst hold", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    rst = 1'b0;
    idle(1);
    xfer(1'b0, 8'h03, 8'h00, 1'b0, 4, 8'hA5, 0);
    idle(1);

    // PSEL dropped in T2 of a read, then a write must still complete in T3.
    xfer(1'b0, 8'h03, 8'h00, 1'b0, 4, 8'hA5, 2);
    xfer(1'b1, 8'h05, 8'h77, 1'b0, 3, 8'h00, 0);
    xfer(1'b0, 8'h05, 8'h00, 1'b0, 4, 8'h77, 0);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 80; n++) begin
      bit         wr;
      logic [7:0] a, d;
      bit         e_err;
      int         lat, drop;
      wr    = 1'($urandom);
      a     = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 21));
      d     = 8'($urandom);
      e_err = (a >= 8'd16);
      lat   = (e_err || wr) ? 3 : 4;
      drop  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(2, lat - 1)) : 0;
      xfer(wr, a, d, e_err, lat, model_mem[a[3:0]], drop);
      idle(int'($urandom_range(0, 2)));
    end
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
